hd44780_byte_sequencer: RTL and testbench

//  Turns byte-wide LCD transactions (RS + 8-bit data) into HD44780 4-bit bus cycles:

---
 rtl/hd44780_byte_sequencer_pkg.sv | 44 ++++
 rtl/hd44780_delay_timer.sv | 37 +++
 rtl/hd44780_byte_sequencer.sv | 175 +++++++++++++++++
 tb/tb_hd44780_byte_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd44780_byte_sequencer_pkg.sv
// Package for the HD44780 byte sequencer.
// Holds the sequencer state encoding, the list of opcodes that need the long
// post-command wait, default cycle counts for the 48 MHz HFOSC clock, and small
// helper functions shared by the top and the timer sizing.
package hd44780_byte_sequencer_pkg;

  // Default phase lengths in 48 MHz clock cycles.
  localparam int DEF_E_SETUP_CYC   = 4;       // RS/data stable before E rises
  localparam int DEF_E_HIGH_CYC    = 24;      // 500 ns E pulse
  localparam int DEF_NYB_GAP_CYC   = 48;      // E low between nybbles
  localparam int DEF_CMD_WAIT_CYC  = 1920;    // 40 us post-byte wait
  localparam int DEF_LONG_WAIT_CYC = 78720;   // 1.64 ms wait for clear/home
  localparam int DEF_INIT_PWR_CYC  = 720000;  // 15 ms power-up wait
  localparam int DEF_INIT_W1_CYC   = 196800;  // 4.1 ms after first 0x3 nybble
  localparam int DEF_INIT_W2_CYC   = 4800;    // 100 us after 2nd/3rd 0x3 nybble

  // Instructions that need the long execution time.
  localparam logic [7:0] OP_CLEAR     = 8'h01;
  localparam logic [7:0] OP_HOME      = 8'h02;
  localparam logic [7:0] OP_HOME_ALT  = 8'h03;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_H,
    ST_E_H,
    ST_GAP,
    ST_SET_L,
    ST_E_L,
    ST_WAIT,
    ST_INIT_PWR,
    ST_INIT_SET,
    ST_INIT_E,
    ST_INIT_WAIT
  } state_t;

  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == OP_CLEAR) || (data == OP_HOME) || (data == OP_HOME_ALT));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hd44780_delay_timer.sv
// Reloadable down-counter used to time LCD bus phases.
// Ports:
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset (counter returns to RST_VAL)
//   i_load      load i_load_val this cycle instead of counting
//   i_load_val  value to load (phase length - 1)
//   o_done      counter has reached zero; the current phase ends at the next edge
// The counter stops at zero rather than wrapping, so o_done stays high until
// the next load.
module hd44780_delay_timer #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/hd44780_byte_sequencer.sv
// HD44780 byte sequencer: converts one RS + 8-bit request into two 4-bit LCD
// bus cycles (high nybble, then low nybble, each with its own E pulse) followed
// by the controller's execution wait. R/~W is assumed tied low (no busy read).
// Ports:
//   i_clk, i_rst_n      clock and asynchronous active-low reset
//   i_valid / o_ready   request handshake; transfer on i_valid & o_ready at a rising edge
//   i_rs, i_data        register select and byte, latched on the accept edge
//   o_lcd_rs, o_lcd_e   LCD RS and E pins (registered)
//   o_lcd_data          LCD D7..D4 (registered)
//   o_init_done         power-up sequence finished
// Configuration macro HD44780_INIT_EN: when defined, reset runs the HD44780
// 4-bit power-up sequence (0x3, 0x3, 0x3, 0x2 nybbles) before accepting bytes;
// when undefined, reset lands in IDLE and o_init_done is tied high.
module hd44780_byte_sequencer
  import hd44780_byte_sequencer_pkg::*;
#(
  parameter int E_SETUP_CYC   = DEF_E_SETUP_CYC,
  parameter int E_HIGH_CYC    = DEF_E_HIGH_CYC,
  parameter int NYB_GAP_CYC   = DEF_NYB_GAP_CYC,
  parameter int CMD_WAIT_CYC  = DEF_CMD_WAIT_CYC,
  parameter int LONG_WAIT_CYC = DEF_LONG_WAIT_CYC,
  parameter int INIT_PWR_CYC  = DEF_INIT_PWR_CYC,
  parameter int INIT_W1_CYC   = DEF_INIT_W1_CYC,
  parameter int INIT_W2_CYC   = DEF_INIT_W2_CYC
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_e,
  output logic [3:0] o_lcd_data,
  output logic       o_init_done
);

  // Sized for the longest phase of any kind so one counter serves all of them.
  localparam int MAX_CYC = max_int(max_int(max_int(E_SETUP_CYC, E_HIGH_CYC),
                                           max_int(NYB_GAP_CYC, CMD_WAIT_CYC)),
                                   max_int(max_int(LONG_WAIT_CYC, INIT_PWR_CYC),
                                           max_int(INIT_W1_CYC, INIT_W2_CYC)));
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

`ifdef HD44780_INIT_EN
  localparam state_t           ST_RESET    = ST_INIT_PWR;
  // The power-up wait starts straight out of reset, so the timer resets to it.
  localparam logic [CNT_W-1:0] TMR_RST_VAL = CNT_W'(INIT_PWR_CYC - 1);
  logic [2:0] r_init_step;  // init nybbles already strobed
  logic       r_init_done;
`else
  localparam state_t           ST_RESET    = ST_IDLE;
  localparam logic [CNT_W-1:0] TMR_RST_VAL = '0;
`endif

  state_t           r_state, w_state_nx;
  logic             r_rs;
  logic [7:0]       r_data;
  logic             r_lcd_rs, r_lcd_e;
  logic [3:0]       r_lcd_data;
  logic             w_accept, w_load, w_done;
  logic [CNT_W-1:0] w_load_val;
  int               w_len;

  assign w_accept = (r_state == ST_IDLE) && i_valid;

  hd44780_delay_timer #(
    .WIDTH   (CNT_W),
    .RST_VAL (TMR_RST_VAL)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (i_valid) w_state_nx = ST_SET_H;
      ST_SET_H: if (w_done)  w_state_nx = ST_E_H;
      ST_E_H:   if (w_done)  w_state_nx = ST_GAP;
      ST_GAP:   if (w_done)  w_state_nx = ST_SET_L;
      ST_SET_L: if (w_done)  w_state_nx = ST_E_L;
      ST_E_L:   if (w_done)  w_state_nx = ST_WAIT;
      ST_WAIT:  if (w_done)  w_state_nx = ST_IDLE;
`ifdef HD44780_INIT_EN
      ST_INIT_PWR:  if (w_done) w_state_nx = ST_INIT_SET;
      ST_INIT_SET:  if (w_done) w_state_nx = ST_INIT_E;
      ST_INIT_E:    if (w_done) w_state_nx = ST_INIT_WAIT;
      ST_INIT_WAIT: if (w_done) w_state_nx = (r_init_step == 3'd4) ? ST_IDLE : ST_INIT_SET;
`endif
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Each state entry reloads the timer with the length of the phase entered.
  always_comb begin
    w_len = 1;
    case (w_state_nx)
      ST_SET_H, ST_SET_L, ST_INIT_SET: w_len = E_SETUP_CYC;
      ST_E_H, ST_E_L, ST_INIT_E:       w_len = E_HIGH_CYC;
      ST_GAP:                          w_len = NYB_GAP_CYC;
      ST_WAIT:  w_len = is_long_cmd(r_rs, r_data) ? LONG_WAIT_CYC : CMD_WAIT_CYC;
`ifdef HD44780_INIT_EN
      // Step is the count before this nybble's increment: 0 -> W1, 3 -> final.
      ST_INIT_WAIT: begin
        if (r_init_step == 3'd0)      w_len = INIT_W1_CYC;
        else if (r_init_step == 3'd3) w_len = CMD_WAIT_CYC;
        else                          w_len = INIT_W2_CYC;
      end
`endif
      default:  w_len = 1;
    endcase
    w_load     = (w_state_nx != r_state);
    w_load_val = CNT_W'(w_len - 1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RESET;
      r_rs       <= 1'b0;
      r_data     <= 8'h00;
      r_lcd_rs   <= 1'b0;
      r_lcd_e    <= 1'b0;
      r_lcd_data <= 4'h0;
    end else begin
      r_state <= w_state_nx;
      r_lcd_e <= (w_state_nx == ST_E_H) || (w_state_nx == ST_E_L) ||
                 (w_state_nx == ST_INIT_E);
      if (w_accept) begin
        r_rs       <= i_rs;
        r_data     <= i_data;
        r_lcd_rs   <= i_rs;
        r_lcd_data <= i_data[7:4];
      end
      if ((r_state == ST_GAP) && (w_state_nx == ST_SET_L)) begin
        r_lcd_data <= r_data[3:0];
      end
`ifdef HD44780_INIT_EN
      if ((w_state_nx == ST_INIT_SET) && (r_state != ST_INIT_SET)) begin
        r_lcd_data <= (r_init_step == 3'd3) ? 4'h2 : 4'h3;
      end
`endif
    end
  end

`ifdef HD44780_INIT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_init_step <= 3'd0;
      r_init_done <= 1'b0;
    end else begin
      if ((r_state == ST_INIT_E) && w_done) begin
        r_init_step <= r_init_step + 3'd1;
      end
      if ((r_state == ST_INIT_WAIT) && (w_state_nx == ST_IDLE)) begin
        r_init_done <= 1'b1;
      end
    end
  end
  assign o_init_done = r_init_done;
`else
  assign o_init_done = 1'b1;
`endif

  assign o_ready    = (r_state == ST_IDLE);
  assign o_lcd_rs   = r_lcd_rs;
  assign o_lcd_e    = r_lcd_e;
  assign o_lcd_data = r_lcd_data;

endmodule

// File: tb/tb_hd44780_byte_sequencer.sv
// Self-checking bench for hd44780_byte_sequencer.
// The reference model expands every accepted byte (and the optional power-up
// sequence) into a list of expected per-cycle pin frames; a compare process
// checks the DUT pins against the current frame on every falling clock edge.
// Directed sections pin the model with hand-computed latencies and nybbles.
module tb_hd44780_byte_sequencer;

  localparam int T_SET  = 2;
  localparam int T_EH   = 4;
  localparam int T_GAP  = 3;
  localparam int T_CMD  = 10;
  localparam int T_LONG = 50;
  localparam int T_PWR  = 20;
  localparam int T_W1   = 8;
  localparam int T_W2   = 5;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_rs    = 1'b0;
  logic [7:0] i_data  = 8'h00;
  logic       o_ready, o_lcd_rs, o_lcd_e, o_init_done;
  logic [3:0] o_lcd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hd44780_byte_sequencer #(
    .E_SETUP_CYC   (T_SET),
    .E_HIGH_CYC    (T_EH),
    .NYB_GAP_CYC   (T_GAP),
    .CMD_WAIT_CYC  (T_CMD),
    .LONG_WAIT_CYC (T_LONG),
    .INIT_PWR_CYC  (T_PWR),
    .INIT_W1_CYC   (T_W1),
    .INIT_W2_CYC   (T_W2)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_rs        (i_rs),
    .i_data      (i_data),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_e     (o_lcd_e),
    .o_lcd_data  (o_lcd_data),
    .o_init_done (o_init_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: expected per-cycle frames ----------------
  typedef struct packed {
    logic       rs;
    logic       e;
    logic [3:0] data;
    logic       ready;
    logic       done;
  } frame_t;

  frame_t q[$];
  frame_t cur;

  function automatic frame_t mk(input logic rs, input logic e, input logic [3:0] d,
                                input logic ready, input logic done);
    frame_t f;
    f.rs = rs; f.e = e; f.data = d; f.ready = ready; f.done = done;
    return f;
  endfunction

  task automatic push_n(input frame_t f, input int n);
    repeat (n) q.push_back(f);
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] d);
    int wait_cyc;
    wait_cyc = (!rs && (d >= 8'h01) && (d <= 8'h03)) ? T_LONG : T_CMD;
    push_n(mk(rs, 1'b0, d[7:4], 1'b0, 1'b1), T_SET);
    push_n(mk(rs, 1'b1, d[7:4], 1'b0, 1'b1), T_EH);
    push_n(mk(rs, 1'b0, d[7:4], 1'b0, 1'b1), T_GAP);
    push_n(mk(rs, 1'b0, d[3:0], 1'b0, 1'b1), T_SET);
    push_n(mk(rs, 1'b1, d[3:0], 1'b0, 1'b1), T_EH);
    push_n(mk(rs, 1'b0, d[3:0], 1'b0, 1'b1), wait_cyc);
  endtask

  task automatic model_reset();
    q.delete();
`ifdef HD44780_INIT_EN
    push_n(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b0), T_PWR);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] nyb;
      int         w;
      nyb = (i == 3) ? 4'h2 : 4'h3;
      w   = (i == 0) ? T_W1 : ((i == 3) ? T_CMD : T_W2);
      push_n(mk(1'b0, 1'b0, nyb, 1'b0, 1'b0), T_SET);
      push_n(mk(1'b0, 1'b1, nyb, 1'b0, 1'b0), T_EH);
      push_n(mk(1'b0, 1'b0, nyb, 1'b0, 1'b0), w);
    end
    cur = q.pop_front();
`else
    cur = mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
`endif
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else if (cur.ready && i_valid) begin
        push_byte(i_rs, i_data);
        cur = q.pop_front();
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end else begin
        cur.ready = 1'b1;
        cur.done  = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("ready",     32'(o_ready),     32'(cur.ready));
      check("lcd_rs",    32'(o_lcd_rs),    32'(cur.rs));
      check("lcd_e",     32'(o_lcd_e),     32'(cur.e));
      check("lcd_data",  32'(o_lcd_data),  32'(cur.data));
      check("init_done", 32'(o_init_done), 32'(cur.done));
    end
  end

  // ---------------- E pulse monitor ----------------
  int         pulses = 0;
  logic [3:0] nyb_q[$];
  logic       prev_e = 1'b0;
  logic [3:0] prev_d = 4'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (prev_e && o_lcd_e) check("data_stable_in_e", 32'(o_lcd_data), 32'(prev_d));
      if (!prev_e && o_lcd_e) begin
        pulses++;
        nyb_q.push_back(o_lcd_data);
      end
      prev_e = o_lcd_e;
      prev_d = o_lcd_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!o_ready && n < budget) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(o_ready), 32'd1);
  endtask

  task automatic send_measure(input logic rs, input logic [7:0] d, output int low);
    wait_ready(300);
    i_valid = 1'b1; i_rs = rs; i_data = d;
    tick();
    i_valid = 1'b0;
    low = 0;
    while (!o_ready && low < 300) begin
      low++;
      tick();
    end
  endtask

  task automatic clear_mon();
    pulses = 0;
    nyb_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int low, low2, hi, n, p0;
    rst_n = 1'b0;
    repeat (3) tick();
    clear_mon();
`ifdef HD44780_INIT_EN
    // Requests during init must be ignored.
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h55;
    rst_n = 1'b1;
    check("init_ready0", 32'(o_ready), 32'd0);
    check("init_done0",  32'(o_init_done), 32'd0);
    n = 0;
    while (!o_init_done && n < 500) begin
      n++;
      tick();
    end
    i_valid = 1'b0;
    check("init_cycles", 32'(n), 32'd72);
    check("init_pulses", 32'(pulses), 32'd4);
    check("init_nyb0", 32'(nyb_q[0]), 32'h3);
    check("init_nyb1", 32'(nyb_q[1]), 32'h3);
    check("init_nyb2", 32'(nyb_q[2]), 32'h3);
    check("init_nyb3", 32'(nyb_q[3]), 32'h2);
`else
    rst_n = 1'b1;
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_e",     32'(o_lcd_e), 32'd0);
    check("rst_rs",    32'(o_lcd_rs), 32'd0);
    check("rst_data",  32'(o_lcd_data), 32'd0);
    check("rst_done",  32'(o_init_done), 32'd1);
`endif
    tick();

    // 1: data byte 0x48
    clear_mon();
    send_measure(1'b1, 8'h48, low);
    check("t1_busy", 32'(low), 32'd25);
    check("t1_pulses", 32'(pulses), 32'd2);
    check("t1_nyb_hi", 32'(nyb_q[0]), 32'h4);
    check("t1_nyb_lo", 32'(nyb_q[1]), 32'h8);
    check("t1_rs_hold", 32'(o_lcd_rs), 32'd1);

    // 2: long-wait selection boundaries
    send_measure(1'b0, 8'h01, low); check("t2_clear_long", 32'(low), 32'd65);
    send_measure(1'b1, 8'h01, low); check("t2_data01_short", 32'(low), 32'd25);
    send_measure(1'b0, 8'h03, low); check("t2_op03_long", 32'(low), 32'd65);
    send_measure(1'b0, 8'h04, low); check("t2_op04_short", 32'(low), 32'd25);
    send_measure(1'b0, 8'h00, low); check("t2_op00_short", 32'(low), 32'd25);

    // 3: valid held high across two bytes
    wait_ready(300);
    clear_mon();
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h41;
    tick();
    i_data = 8'h42;
    low = 0;
    while (!o_ready && low < 300) begin low++; tick(); end
    hi = 0;
    while (o_ready && hi < 10) begin hi++; tick(); end
    i_valid = 1'b0;
    low2 = 0;
    while (!o_ready && low2 < 300) begin low2++; tick(); end
    check("t3_busy1", 32'(low), 32'd25);
    check("t3_idle_gap", 32'(hi), 32'd1);
    check("t3_busy2", 32'(low2), 32'd25);
    check("t3_pulses", 32'(pulses), 32'd4);
    check("t3_nyb0", 32'(nyb_q[0]), 32'h4);
    check("t3_nyb1", 32'(nyb_q[1]), 32'h1);
    check("t3_nyb2", 32'(nyb_q[2]), 32'h4);
    check("t3_nyb3", 32'(nyb_q[3]), 32'h2);

    // 5: valid toggling while busy is ignored
    wait_ready(300);
    clear_mon();
    i_valid = 1'b1; i_rs = 1'b0; i_data = 8'h5A;
    tick();
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'($urandom);
      i_rs    = 1'($urandom);
      i_data  = 8'($urandom);
      tick();
    end
    i_valid = 1'b0;
    wait_ready(300);
    check("t5_pulses", 32'(pulses), 32'd2);
    check("t5_nyb_hi", 32'(nyb_q[0]), 32'h5);
    check("t5_nyb_lo", 32'(nyb_q[1]), 32'hA);
    check("t5_rs", 32'(o_lcd_rs), 32'd0);

    // 4: asynchronous reset in the middle of an E pulse
    i_valid = 1'b1; i_rs = 1'b1; i_data = 8'h77;
    tick();
    i_valid = 1'b0;
    n = 0;
    while (!o_lcd_e && n < 20) begin n++; tick(); end
    check("t4_e_seen", 32'(o_lcd_e), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check("t4_e_drop", 32'(o_lcd_e), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
`ifdef HD44780_INIT_EN
    check("t4_ready_init", 32'(o_ready), 32'd0);
    check("t4_done_init", 32'(o_init_done), 32'd0);
    wait_ready(300);
`else
    check("t4_ready", 32'(o_ready), 32'd1);
    p0 = pulses;
    repeat (30) tick();
    check("t4_no_stale", 32'(pulses), 32'(p0));
`endif

    // Randomized traffic, including back-to-back and long-wait opcodes.
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      i_valid = 1'b0; i_rs = 1'($urandom); i_data = 8'($urandom);
      repeat (gap) tick();
      i_rs   = 1'($urandom);
      i_data = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      i_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 300) begin n++; tick(); end
      check("rand_ready", 32'(o_ready), 32'd1);
      tick();
    end
    i_valid = 1'b0;
    wait_ready(300);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
